// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock with a registered
// inter-chunk carry; results are held stable between completions.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ofl
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [CHUNK:0]   sum_c;
    logic             accept_c, step_c, last_c, ofl_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (cnt_q == CW'(NCH - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // One chunk of the ripple, merged into the partial result
    always_comb begin
        sum_c   = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]}
                + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, c_q};
        res_nxt = res_q;
        res_nxt[cnt_q*CHUNK +: CHUNK] = sum_c[CHUNK-1:0];
        ofl_c   = (a_q[MSB] == b_q[MSB]) && (res_nxt[MSB] != a_q[MSB]);
    end

    // Operand latch, chunk sequencing and result publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            res_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            Ofl   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                // Subtraction becomes A + ~B + ~Cin, so Cout=1 means no borrow
                a_q   <= A;
                b_q   <= sub ? ~B : B;
                c_q   <= sub ? ~Cin : Cin;
                cnt_q <= '0;
                busy  <= 1'b1;
            end
            if (step_c) begin
                res_q <= res_nxt;
                c_q   <= sum_c[CHUNK];
                cnt_q <= cnt_q + CW'(1);
            end
            if (last_c) begin
                S    <= res_nxt;
                Cout <= sum_c[CHUNK];
                Ofl  <= ofl_c;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: four parameterisations share one stimulus bus and are
// checked every cycle against an arithmetic reference, plus literal results on 16/4.
module tb_seq_chunk_adder;

    localparam int NI = 4;
    localparam int WD [NI] = '{16, 16, 16, 32};
    localparam int NC [NI] = '{4, 1, 16, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;

    logic [NI-1:0] busy_w, done_w, cout_w, ofl_w;
    logic [15:0]   s0, s1, s2;
    logic [31:0]   s3;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a_in[15:0]), .B(b_in[15:0]),
        .Cin(cin), .busy(busy_w[0]), .done(done_w[0]), .S(s0), .Cout(cout_w[0]), .Ofl(ofl_w[0]));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a_in[15:0]), .B(b_in[15:0]),
        .Cin(cin), .busy(busy_w[1]), .done(done_w[1]), .S(s1), .Cout(cout_w[1]), .Ofl(ofl_w[1]));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u2 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a_in[15:0]), .B(b_in[15:0]),
        .Cin(cin), .busy(busy_w[2]), .done(done_w[2]), .S(s2), .Cout(cout_w[2]), .Ofl(ofl_w[2]));
    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u3 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a_in), .B(b_in),
        .Cin(cin), .busy(busy_w[3]), .done(done_w[3]), .S(s3), .Cout(cout_w[3]), .Ofl(ofl_w[3]));

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Hand-computed results expected from the 16/4 instance, in completion order
    logic [15:0] lit_s [16];
    logic        lit_c [16];
    logic        lit_o [16];
    int          lit_n = 0;
    int          lit_rd = 0;
    logic        finish_req = 1'b0;

    // Reference: plain integer arithmetic on the masked operands
    function automatic longint sx(input longint unsigned x, input int w);
        return x[w-1] ? (longint'(x) - (longint'(1) <<< w)) : longint'(x);
    endfunction

    function automatic void ref_calc(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic ci, input logic sb,
                                     output logic [31:0] s, output logic co, output logic ov);
        longint unsigned mask, ua, ub;
        longint t, sa, sbv, st, lim, cv;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        cv   = ci ? 64'sd1 : 64'sd0;
        sa   = sx(ua, w);
        sbv  = sx(ub, w);
        lim  = longint'(64'd1 << (w - 1));
        if (!sb) begin
            t  = longint'(ua) + longint'(ub) + cv;
            co = (t >= 2 * lim);
            st = sa + sbv + cv;
        end else begin
            t  = longint'(ua) - longint'(ub) - cv;
            co = (t >= 0);
            st = sa - sbv - cv;
        end
        s  = 32'(t) & 32'(mask);
        ov = (st >= lim) || (st < -lim);
    endfunction

    // Cycle-level behaviour: accept when idle, publish NCH edges later
    logic [31:0] m_s [NI];
    logic [31:0] p_s [NI];
    logic [NI-1:0] m_c, m_o, m_done, m_busy, p_c, p_o;
    int          m_rem [NI];

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] rs;
        logic        rc, ro;
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_rem[i] <= 0;
                m_s[i] <= '0; m_c[i] <= 1'b0; m_o[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (m_rem[i] == 1) begin
                        m_busy[i] <= 1'b0; m_done[i] <= 1'b1;
                        m_s[i] <= p_s[i]; m_c[i] <= p_c[i]; m_o[i] <= p_o[i];
                    end
                    m_rem[i] <= m_rem[i] - 1;
                end else if (start) begin
                    ref_calc(WD[i], a_in, b_in, cin, sub, rs, rc, ro);
                    p_s[i] <= rs; p_c[i] <= rc; p_o[i] <= ro;
                    m_busy[i] <= 1'b1; m_rem[i] <= NC[i];
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    // Single compare process, sampled on the falling edge
    always @(negedge clk) begin : compare
        logic [31:0] sv [NI];
        sv[0] = {16'd0, s0}; sv[1] = {16'd0, s1}; sv[2] = {16'd0, s2}; sv[3] = s3;
        if (finish_req) begin
            chk("lit_count", 0, 32'(lit_rd), 32'(lit_n));
            $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
            $finish;
        end else begin
            for (int i = 0; i < NI; i++) begin
                chk("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
                chk("done", i, 32'(done_w[i]), 32'(m_done[i]));
                chk("S",    i, sv[i],          m_s[i]);
                chk("Cout", i, 32'(cout_w[i]), 32'(m_c[i]));
                chk("Ofl",  i, 32'(ofl_w[i]),  32'(m_o[i]));
            end
            if (done_w[0] && lit_rd < lit_n) begin
                chk("lit_S",    0, {16'd0, s0},     {16'd0, lit_s[lit_rd]});
                chk("lit_Cout", 0, 32'(cout_w[0]), 32'(lit_c[lit_rd]));
                chk("lit_Ofl",  0, 32'(ofl_w[0]),  32'(lit_o[lit_rd]));
                lit_rd++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        a_in = {16'd0, a}; b_in = {16'd0, b}; cin = ci; sub = sb;
    endtask

    task automatic push_lit(input logic [15:0] s, input logic c, input logic o);
        lit_s[lit_n] = s; lit_c[lit_n] = c; lit_o[lit_n] = o;
        lit_n++;
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                      input logic [15:0] es, input logic ec, input logic eo);
        drive(a, b, ci, sb);
        start = 1'b1;
        push_lit(es, ec, eo);
        tick();
        start = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

        // Start pulse and operand changes while running are ignored
        drive(16'h0100, 16'h0020, 1'b0, 1'b0);
        start = 1'b1;
        push_lit(16'h0120, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();

        // Start held high: back-to-back operations every NCH+1 cycles
        drive(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        start = 1'b1;
        push_lit(16'h1000, 1'b0, 1'b0);
        repeat (5) tick();
        drive(16'h2000, 16'h0001, 1'b0, 1'b0);
        push_lit(16'h2001, 1'b0, 1'b0);
        repeat (5) tick();
        drive(16'h0003, 16'h0004, 1'b0, 1'b1);
        push_lit(16'hFFFF, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        repeat (5) tick();

        // Asynchronous reset in the middle of a run: aborted, no done
        drive(16'h4444, 16'h1111, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #3 rst = 1'b1;
        repeat (2) tick();
        #3 rst = 1'b0;
        tick();
        op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

        // Random sweep; the CHUNK=1 instance completes ~1000 operations
        start = 1'b1;
        repeat (17200) begin
            a_in = $urandom;
            b_in = $urandom;
            cin  = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        repeat (20) tick();
        finish_req = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
